// File: rtl/apu_frame_sequencer_if.sv
// CPU-side register strobes into the frame sequencer and the frame clocks it drives out.
// Inputs are single-cycle strobes sampled on the rising clk edge; quarter/half are 1-cycle pulses.
interface apu_frame_sequencer_if;
   logic       wr_en;
   logic [1:0] wr_data;
   logic       irq_ack;
   logic       quarter_frame;
   logic       half_frame;
   logic       frame_irq;
   logic       mode;

   modport master (
      output wr_en, wr_data, irq_ack,
      input  quarter_frame, half_frame, frame_irq, mode
   );

   modport slave (
      input  wr_en, wr_data, irq_ack,
      output quarter_frame, half_frame, frame_irq, mode
   );
endinterface

// File: rtl/apu_frame_sequencer.sv
// APU frame counter: quarter/half frame strobes, frame IRQ and the delayed $4017 restart.
// Every output is a flop fed from a decode of the next cycle count.
module apu_frame_sequencer #(
   parameter int unsigned Q1          = 7457,
   parameter int unsigned Q2          = 14913,
   parameter int unsigned Q3          = 22371,
   parameter int unsigned Q4_4STEP    = 29829,
   parameter int unsigned Q4_5STEP    = 37281,
   parameter int unsigned WRITE_DELAY = 3,
   parameter int unsigned CW          = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   apu_frame_sequencer_if.slave  bus
);

   localparam logic [CW-1:0] Q1_C   = CW'(Q1);
   localparam logic [CW-1:0] Q2_C   = CW'(Q2);
   localparam logic [CW-1:0] Q3_C   = CW'(Q3);
   localparam logic [CW-1:0] Q44_C  = CW'(Q4_4STEP);
   localparam logic [CW-1:0] Q45_C  = CW'(Q4_5STEP);
   localparam logic [CW-1:0] ONE_C  = CW'(1);
   localparam logic [2:0]    WD_C   = 3'(WRITE_DELAY);

   logic [CW-1:0] cyc_q, cyc_d;
   logic [2:0]    pend_q, pend_d;
   logic          mode_q, mode_d;
   logic          inhibit_q, inhibit_d;
   logic          irq_q, irq_d;
   logic          qf_q, qf_d;
   logic          hf_q, hf_d;
   logic          restart;
   logic          irq_set;
   logic          irq_clr;
   logic [CW-1:0] last_cur;
   logic [CW-1:0] last_nxt;

   always_comb begin
      mode_d    = mode_q;
      inhibit_d = inhibit_q;
      pend_d    = pend_q;
      restart   = 1'b0;
      // A new write always re-arms the delay; only the newest write can restart.
      if (bus.wr_en) begin
         mode_d    = bus.wr_data[1];
         inhibit_d = bus.wr_data[0];
         pend_d    = WD_C;
      end else if (pend_q != 3'd0) begin
         pend_d  = pend_q - 3'd1;
         restart = (pend_q == 3'd1);
      end

      last_cur = mode_q ? Q45_C : Q44_C;
      last_nxt = mode_d ? Q45_C : Q44_C;

      if (restart || (cyc_q == last_cur)) begin
         cyc_d = '0;
      end else begin
         cyc_d = cyc_q + ONE_C;
      end

      // The restart cycle replaces the normal step decode: 5-step mode clocks immediately.
      if (restart) begin
         qf_d = mode_d;
         hf_d = mode_d;
      end else begin
         qf_d = (cyc_d == Q1_C) || (cyc_d == Q2_C) || (cyc_d == Q3_C) || (cyc_d == last_nxt);
         hf_d = (cyc_d == Q2_C) || (cyc_d == last_nxt);
      end

      irq_set = !restart && (cyc_d == Q44_C) && !mode_d && !inhibit_d;
      irq_clr = bus.irq_ack || (bus.wr_en && bus.wr_data[0]);
      irq_d   = irq_set || (irq_q && !irq_clr);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cyc_q     <= '0;
         pend_q    <= 3'd0;
         mode_q    <= 1'b0;
         inhibit_q <= 1'b0;
         irq_q     <= 1'b0;
         qf_q      <= 1'b0;
         hf_q      <= 1'b0;
      end else begin
         cyc_q     <= cyc_d;
         pend_q    <= pend_d;
         mode_q    <= mode_d;
         inhibit_q <= inhibit_d;
         irq_q     <= irq_d;
         qf_q      <= qf_d;
         hf_q      <= hf_d;
      end
   end

   assign bus.quarter_frame = qf_q;
   assign bus.half_frame    = hf_q;
   assign bus.frame_irq     = irq_q;
   assign bus.mode          = mode_q;

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Directed bench for apu_frame_sequencer, run with shortened step counts so every
// scenario (both modes, IRQ set/clear, restarts, reset mid-write) fits in a few hundred cycles.
module tb_apu_frame_sequencer;
   localparam int Q1   = 20;
   localparam int Q2   = 41;
   localparam int Q3   = 62;
   localparam int Q4_4 = 83;
   localparam int Q4_5 = 104;
   localparam int WD   = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;

   apu_frame_sequencer_if bus();

   apu_frame_sequencer #(
      .Q1(Q1), .Q2(Q2), .Q3(Q3), .Q4_4STEP(Q4_4), .Q4_5STEP(Q4_5),
      .WRITE_DELAY(WD), .CW(16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int   n_assert = 0;
   int   n_fail   = 0;
   int   cyc_e;
   logic mode_e;
   logic inh_e;
   logic irq_e;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int last_e();
      return mode_e ? Q4_5 : Q4_4;
   endfunction

   task automatic chk_outs(input string tag, input logic qf_x, input logic hf_x);
      chk({tag, "_qf"},   bus.quarter_frame, qf_x);
      chk({tag, "_hf"},   bus.half_frame,    hf_x);
      chk({tag, "_irq"},  bus.frame_irq,     irq_e);
      chk({tag, "_mode"}, bus.mode,          mode_e);
   endtask

   // One normal sequencer cycle: advance the expected count and check all outputs.
   task automatic tick(input string tag);
      logic qf_x;
      logic hf_x;
      @(posedge clk);
      #1;
      cyc_e = (cyc_e == last_e()) ? 0 : cyc_e + 1;
      if (cyc_e == Q4_4 && !mode_e && !inh_e) irq_e = 1'b1;
      qf_x = (cyc_e == Q1) || (cyc_e == Q2) || (cyc_e == Q3) || (cyc_e == last_e());
      hf_x = (cyc_e == Q2) || (cyc_e == last_e());
      chk_outs(tag, qf_x, hf_x);
   endtask

   task automatic restart_tick(input string tag);
      @(posedge clk);
      #1;
      cyc_e = 0;
      chk_outs(tag, mode_e, mode_e);
   endtask

   task automatic run_to(input int target, input string tag);
      for (int i = 0; i < 400 && cyc_e != target; i++) tick(tag);
   endtask

   task automatic write(input logic [1:0] d, input string tag);
      bus.wr_en   = 1'b1;
      bus.wr_data = d;
      mode_e      = d[1];
      inh_e       = d[0];
      if (d[0]) irq_e = 1'b0;
      tick(tag);
      bus.wr_en   = 1'b0;
      bus.wr_data = 2'b00;
   endtask

   task automatic ack(input string tag);
      bus.irq_ack = 1'b1;
      irq_e       = 1'b0;
      tick(tag);
      bus.irq_ack = 1'b0;
   endtask

   task automatic model_reset();
      cyc_e  = 0;
      mode_e = 1'b0;
      inh_e  = 1'b0;
      irq_e  = 1'b0;
   endtask

   initial begin
      bus.wr_en   = 1'b0;
      bus.wr_data = 2'b00;
      bus.irq_ack = 1'b0;
      model_reset();

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_qf",   bus.quarter_frame, 1'b0);
      chk("rst_hf",   bus.half_frame,    1'b0);
      chk("rst_irq",  bus.frame_irq,     1'b0);
      chk("rst_mode", bus.mode,          1'b0);
      @(negedge clk);
      rst = 1'b0;

      // 4-step period; irq_ack on the setting edge loses to the set
      tick("start");
      run_to(Q4_4 - 1, "p1");
      ack("set_ack");
      chk("irq_set_wins", bus.frame_irq, 1'b1);
      chk("p1_final_hf", bus.half_frame, 1'b1);
      tick("p1_wrap");
      chk("p1_wrap_qf", bus.quarter_frame, 1'b0);
      ack("ack_pulse");
      chk("irq_ack_clear", bus.frame_irq, 1'b0);

      // Plain IRQ rise at the final step, then wrap to cyc 0
      run_to(Q4_4 - 1, "p2");
      tick("p2_final");
      chk("irq_rise", bus.frame_irq, 1'b1);
      chk("p2_final_qf", bus.quarter_frame, 1'b1);
      tick("p2_wrap");

      // Inhibit write clears the flag; no IRQ over two full periods
      write(2'b01, "inh_wr");
      chk("wr_clear_irq", bus.frame_irq, 1'b0);
      tick("inh_d1");
      tick("inh_d2");
      restart_tick("inh_restart");
      chk("inh_restart_qf", bus.quarter_frame, 1'b0);
      repeat (2 * (Q4_4 + 1)) tick("inh_run");
      chk("inh_no_irq", bus.frame_irq, 1'b0);

      // 5-step write at cyc 10: restart clocks both strobes, then full 5-step period
      run_to(9, "m5_pre");
      write(2'b10, "m5_wr");
      tick("m5_d1");
      tick("m5_d2");
      restart_tick("m5_restart");
      chk("m5_restart_qf", bus.quarter_frame, 1'b1);
      chk("m5_restart_hf", bus.half_frame, 1'b1);
      run_to(Q4_4, "m5_run");
      chk("m5_no_step_at_q44", bus.quarter_frame, 1'b0);
      run_to(Q4_5, "m5_run");
      chk("m5_final_hf", bus.half_frame, 1'b1);
      chk("m5_no_irq", bus.frame_irq, 1'b0);
      tick("m5_wrap");

      // Switch 5->4 step while cyc is beyond the 4-step final step
      run_to(90, "sw_pre");
      write(2'b00, "sw_wr");
      tick("sw_d1");
      tick("sw_d2");
      restart_tick("sw_restart");
      chk("sw_restart_qf", bus.quarter_frame, 1'b0);

      // Second write during the pending delay: single restart using the newest data
      run_to(5, "dbl_pre");
      write(2'b01, "dbl_wr1");
      tick("dbl_e1");
      write(2'b10, "dbl_wr2");
      tick("dbl_e3");
      chk("dbl_no_strobe_e3", bus.quarter_frame, 1'b0);
      tick("dbl_e4");
      restart_tick("dbl_restart");
      chk("dbl_restart_qf", bus.quarter_frame, 1'b1);
      chk("dbl_mode", bus.mode, 1'b1);

      // Reset one cycle after a 5-step write aborts the pending restart
      run_to(5, "rw_pre");
      write(2'b10, "rw_wr");
      tick("rw_e1");
      #2;
      rst = 1'b1;
      #1;
      chk("rw_rst_qf",   bus.quarter_frame, 1'b0);
      chk("rw_rst_hf",   bus.half_frame,    1'b0);
      chk("rw_rst_irq",  bus.frame_irq,     1'b0);
      chk("rw_rst_mode", bus.mode,          1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      run_to(Q1, "post_rst");
      chk("post_rst_q1", bus.quarter_frame, 1'b1);
      chk("post_rst_mode", bus.mode, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
